// File: rtl/rr_arb4_enc.sv
// Round-robin arbiter for four requesters, encoding the grant as a 2-bit index plus enable
// for a downstream 2-to-4 decoder; grants are held until done, request drop or hold timeout.
module rr_arb4_enc #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic       e,
  output logic       a,
  output logic       b,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic [1:0] own_q, own_d;
  logic [1:0] last_q, last_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       e_q, e_d;
  logic       timeout_q, timeout_d;

  logic [1:0] win;
  logic [1:0] cand;
  logic       found;
  logic       owner_req;
  logic       tmo_hit;

  // Requester n sits on req[3-n], which for a 2-bit index is req[~n].
  always_comb begin
    win   = last_q;
    cand  = last_q;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_q + 2'(i);
      if (!found && req[~cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  assign owner_req = req[~own_q];
  assign tmo_hit   = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);

  always_comb begin
    state_d    = state_q;
    own_d      = own_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          own_d      = win;
          last_d     = win;
          hold_cnt_d = 8'd0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (done || !owner_req) begin
          state_d = IDLE;
        end else if (tmo_hit) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else if (hold_cnt_q != 8'hff) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    e_d = (state_d == GRANT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      own_q      <= 2'd0;
      last_q     <= 2'd3;
      hold_cnt_q <= 8'd0;
      e_q        <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      own_q      <= own_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      e_q        <= e_d;
      timeout_q  <= timeout_d;
    end
  end

  assign e       = e_q;
  assign a       = own_q[1];
  assign b       = own_q[0];
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arb4_enc.sv
// Bench for rr_arb4_enc: three instances (MAX_HOLD 8, 1, 0) share stimulus and are
// compared every cycle against a per-instance behavioural model.
module tb_rr_arb4_enc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [2:0] e_o, a_o, b_o, t_o;

  int n_chk  = 0;
  int n_pass = 0;

  localparam int MH [3] = '{8, 1, 0};

  // Model state: grant flag, owner, last owner, cycles e has been high, timeout pulse
  int m_gnt [3];
  int m_own [3];
  int m_last[3];
  int m_held[3];
  int m_tmo [3];

  always #5 clk = ~clk;

  rr_arb4_enc #(.MAX_HOLD(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .e(e_o[0]), .a(a_o[0]), .b(b_o[0]), .timeout(t_o[0]));
  rr_arb4_enc #(.MAX_HOLD(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .e(e_o[1]), .a(a_o[1]), .b(b_o[1]), .timeout(t_o[1]));
  rr_arb4_enc #(.MAX_HOLD(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .e(e_o[2]), .a(a_o[2]), .b(b_o[2]), .timeout(t_o[2]));

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [3:0] dec(input logic en, input logic [1:0] idx);
    dec = en ? (4'b1000 >> idx) : 4'b0000;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_gnt[i] = 0; m_own[i] = 0; m_last[i] = 3; m_held[i] = 0; m_tmo[i] = 0;
    end
  endtask

  task automatic model_step(input logic [3:0] r, input logic d);
    int cand;
    int found;
    for (int i = 0; i < 3; i++) begin
      m_tmo[i] = 0;
      if (m_gnt[i] == 0) begin
        found = 0;
        for (int k = 1; k <= 4; k++) begin
          cand = (m_last[i] + k) % 4;
          if (found == 0 && r[3 - cand]) begin
            found = 1;
            m_own[i] = cand; m_last[i] = cand; m_gnt[i] = 1; m_held[i] = 1;
          end
        end
      end else if (d || !r[3 - m_own[i]]) begin
        m_gnt[i] = 0;
      end else if (MH[i] != 0 && m_held[i] == MH[i]) begin
        m_gnt[i] = 0; m_tmo[i] = 1;
      end else begin
        m_held[i]++;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("e[mh%0d]", MH[i]), e_o[i], m_gnt[i]);
      chk($sformatf("ab[mh%0d]", MH[i]), {a_o[i], b_o[i]}, m_own[i]);
      chk($sformatf("timeout[mh%0d]", MH[i]), t_o[i], m_tmo[i]);
    end
  endtask

  task automatic step(input logic [3:0] r, input logic d);
    req = r; done = d;
    @(posedge clk);
    model_step(r, d);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int cnt;
    int guard;
    logic [3:0] r;
    rst_n = 1'b0; req = 4'b0000; done = 1'b0;
    model_reset();
    #1;
    chk("rst_e", e_o[0], 0);
    chk("rst_ab", {a_o[0], b_o[0]}, 0);
    chk("rst_timeout", t_o[0], 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset in the middle of a grant
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b0);
    chk("pre_rst_e", e_o[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_e", e_o[0], 0);
    chk("async_rst_ab", {a_o[0], b_o[0]}, 0);
    chk("async_rst_t", t_o[0], 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1111, 1'b0);
    chk("rst_first_y", dec(e_o[0], {a_o[0], b_o[0]}), 4'b1000);

    // Rotation with done one cycle into each grant
    for (int i = 1; i <= 4; i++) begin
      step(4'b1111, 1'b1);
      chk("rot_gap_e", e_o[0], 0);
      step(4'b1111, 1'b0);
      chk("rot_e", e_o[0], 1);
      chk("rot_idx", {a_o[0], b_o[0]}, i % 4);
    end

    // Skip and wrap from last = 2 to index 0
    step(4'b1111, 1'b1);
    step(4'b0010, 1'b0);
    chk("wrap_setup_idx", {a_o[0], b_o[0]}, 2);
    step(4'b0010, 1'b1);
    step(4'b1000, 1'b0);
    chk("wrap_e", e_o[0], 1);
    chk("wrap_idx", {a_o[0], b_o[0]}, 0);

    // Timeout: owner 0 drops, index 1 holds with done low
    step(4'b0100, 1'b0);
    chk("tmo_drop_e", e_o[0], 0);
    step(4'b0100, 1'b0);
    chk("tmo_gnt_e", e_o[0], 1);
    cnt = 1; guard = 0;
    while (e_o[0] && guard < 40) begin
      step(4'b0100, 1'b0);
      guard++;
      if (e_o[0]) cnt++;
    end
    chk("tmo_len", cnt, 8);
    chk("tmo_pulse", t_o[0], 1);
    step(4'b0100, 1'b0);
    chk("tmo_regrant_e", e_o[0], 1);
    chk("tmo_regrant_idx", {a_o[0], b_o[0]}, 1);
    chk("tmo_pulse_end", t_o[0], 0);

    // done on the last allowed hold cycle wins over the timeout
    for (int i = 0; i < 7; i++) step(4'b0100, 1'b0);
    chk("dbt_hold_e", e_o[0], 1);
    step(4'b0100, 1'b1);
    chk("dbt_e", e_o[0], 0);
    chk("dbt_timeout", t_o[0], 0);

    // No preemption, then owner drops its request
    step(4'b0100, 1'b0);
    chk("np_idx", {a_o[0], b_o[0]}, 1);
    for (int i = 0; i < 3; i++) step(4'b1100, 1'b0);
    chk("np_hold_e", e_o[0], 1);
    chk("np_hold_idx", {a_o[0], b_o[0]}, 1);
    step(4'b1000, 1'b0);
    chk("np_drop_e", e_o[0], 0);
    step(4'b1000, 1'b0);
    chk("np_next_e", e_o[0], 1);
    chk("np_next_idx", {a_o[0], b_o[0]}, 0);

    // Randomized traffic with mostly-held requests
    r = 4'b1111;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      step(r, ($urandom_range(0, 7) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rr_arb4_enc.md
# rr_arb4_enc

Four-requester round-robin arbiter that drives the 2-to-4 decoder with enable directly downstream. It outputs the winner as a 2-bit index on `a`/`b` with enable `e`, so the decoder turns the grant into a one-hot `y`. It holds each grant until the owner signals `done`, withdraws its request, or a hold timeout expires. After each grant it inserts one idle cycle, then re-arbitrates.

## Interface
- `MAX_HOLD`, default 8: maximum cycles a grant may be held. 0 disables the timeout. Legal range is 0..255.
- `clk`, input, 1: single clock. All logic is rising-edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req`, input, 4: request vector. Requester n (n = 0..3) drives `req[3-n]`, which is the same bit position the decoder asserts in `y` for index n.
- `done`, input, 1: the current owner releases its grant. Sampled only in GRANT.
- `e`, output, 1: grant valid. Connects to the decoder enable.
- `a`, output, 1: granted index, MSB.
- `b`, output, 1: granted index, LSB.
- `timeout`, output, 1: one-cycle pulse when a grant is revoked by `MAX_HOLD`.

## Operation
- Two states:
  - IDLE: `e` = 0.
  - GRANT: `e` = 1, `{a,b}` = owner index.
- Internal registers:
  - `last`, 2 bits: index of the most recent owner.
  - `hold_cnt`, 8 bits.
- IDLE:
  - If `req` ≠ 0 at a clock edge, the winner is the first requesting index searched from (`last`+1) mod 4 upward, wrapping.
  - On that edge: `{a,b}` ← winner, `last` ← winner, `hold_cnt` ← 0, state ← GRANT.
  - If `req` = 0, the block stays in IDLE. `a`/`b` keep their last values.
- GRANT release conditions, evaluated each edge in priority order:
  1. `done` = 1.
  2. The owner's request bit `req[3-owner]` = 0.
  3. `MAX_HOLD` ≠ 0 and `hold_cnt` = `MAX_HOLD`-1.
- On any release: state ← IDLE and `e` ← 0. `timeout` ← 1 only when condition 3 alone caused the release.
- If no release condition holds: `hold_cnt` increments. The counter saturates at 255.
- Requests from non-owners never preempt a grant.
- `timeout` is 0 in every cycle except the single cycle after a timeout release.
- Reset values: state IDLE, `e` = 0, `a` = 0, `b` = 0, `timeout` = 0, `hold_cnt` = 0, `last` = 3. With `last` = 3, index 0 has first priority after reset.

## Timing
- Grant latency: `req` sampled at edge k gives `e` = 1 with a valid `{a,b}` from edge k until edge k+1 or later. That is one cycle of latency.
- Release latency: a release condition sampled at edge m gives `e` = 0 from edge m onward.
- The earliest next grant is at edge m+1, so there is at least one `e` = 0 cycle between any two grants. The decoder therefore never shows two owners back-to-back without an all-zero `y`.
- Grant duration:
  - With `done` tied low and the request held: exactly `MAX_HOLD` cycles of `e` = 1.
  - `MAX_HOLD` = 1: single-cycle grants.
  - `MAX_HOLD` = 0: unbounded.
- `{a,b}` changes only on the edge that enters GRANT. It is stable for the whole grant.
- Simultaneous `done` and timeout at the same edge: a normal release with no `timeout` pulse.
- A request that drops and reasserts within IDLE is treated like any other request. There is no memory of pending requests.
- Asynchronous reset mid-grant: `e`, `a`, `b` and `timeout` go to 0 immediately, without waiting for a clock edge. Arbitration restarts from index 0 after `rst_n` rises.

## Test plan
- Reset check: assert `rst_n` = 0 mid-grant with `req` = 4'b1111. Required: `e` falls at once. After release, the first grant is `{a,b}` = 00, and the decoder shows `y` = 4'b1000.
- Rotation: hold `req` = 4'b1111 and pulse `done` one cycle into each grant. Required: indices 0, 1, 2, 3, 0 in order, with `e` = 0 for exactly one cycle between grants.
- Skip and wrap: with `last` = 2, apply `req` = 4'b1000 (index 0 only). Required: index 3 is skipped and the grant is `{a,b}` = 00 one cycle after the request is sampled.
- Timeout: with `MAX_HOLD` = 8, hold `req` = 4'b0100 and keep `done` = 0. Required: `e` high for exactly 8 cycles, `timeout` high for 1 cycle as `e` falls, then a re-grant to index 1 after one idle cycle.
- Done beats timeout: assert `done` on the last allowed hold cycle. Required: release with `timeout` = 0.
- No preemption and request drop: owner 1 holds while `req[3]` rises; the new request must not take the grant. Then the owner drops `req[2]`. Required: `e` = 0 on the next edge, and the next grant goes to index 0 (wrapping from index 1).
